// File: rtl/pkt_input_ctrl_pkg.sv
// Shared types and constants for the packet input conditioning stage.
// Holds the debouncer state encoding and the default widths.
package pkt_input_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

  localparam int CNT_W_DEF = 12;
  localparam int NUM_W     = 2;

endpackage

// File: rtl/pkt_input_ctrl_if.sv
// Board-side bundle for pkt_input_ctrl: raw inputs in, clean strobes and counters out.
// The slave modport is the controller's view; master is the driver of the raw inputs.
interface pkt_input_ctrl_if
  import pkt_input_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             btn_send;
  logic             btn_out;
  logic [NUM_W-1:0] sw_num;
  logic [NUM_W-1:0] num;
  logic             send_strobe;
  logic             out_strobe;
  logic [CNT_W-1:0] out_now;
  logic [CNT_W-1:0] sent_count;

  modport master (
    output btn_send, btn_out, sw_num,
    input  num, send_strobe, out_strobe, out_now, sent_count
  );

  modport slave (
    input  btn_send, btn_out, sw_num,
    output num, send_strobe, out_strobe, out_now, sent_count
  );

endinterface

// File: rtl/pkt_input_ctrl_btn_debounce.sv
// Synchronizes one raw pushbutton and emits a single-cycle press event
// after DEBOUNCE_CYCLES consecutive stable high samples.
//   state        | meaning
//   IDLE         | button released and qualified
//   PRESS_WAIT   | counting stable high samples toward a press
//   HELD         | press accepted, event already issued
//   RELEASE_WAIT | counting stable low samples toward release
module btn_debounce
  import pkt_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic      sync1_q, sync2_q;
  db_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          press_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/pkt_input_ctrl.sv
// Input conditioning for the QoS packet buffer: debounced send/output strobes,
// packet-class latch, send-before-out arbitration and the two event counters.
module pkt_input_ctrl
  import pkt_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  pkt_input_ctrl_if.slave   bus
);

  logic             send_press, out_press;
  logic [NUM_W-1:0] sw_meta_q, sw_sync_q;
  logic [NUM_W-1:0] num_q, num_d;
  logic             send_strobe_q, send_strobe_d;
  logic             out_strobe_q, out_strobe_d;
  logic             out_pending_q, out_pending_d;
  logic [CNT_W-1:0] sent_count_q, sent_count_d;
  logic [CNT_W-1:0] out_now_q, out_now_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_send (
    .clock     (clock),
    .reset_n   (reset_n),
    .btn_raw_i (bus.btn_send),
    .press_o   (send_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_out (
    .clock     (clock),
    .reset_n   (reset_n),
    .btn_raw_i (bus.btn_out),
    .press_o   (out_press)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta_q     <= '0;
      sw_sync_q     <= '0;
      num_q         <= '0;
      send_strobe_q <= 1'b0;
      out_strobe_q  <= 1'b0;
      out_pending_q <= 1'b0;
      sent_count_q  <= '0;
      out_now_q     <= '0;
    end else begin
      sw_meta_q     <= bus.sw_num;
      sw_sync_q     <= sw_meta_q;
      num_q         <= num_d;
      send_strobe_q <= send_strobe_d;
      out_strobe_q  <= out_strobe_d;
      out_pending_q <= out_pending_d;
      sent_count_q  <= sent_count_d;
      out_now_q     <= out_now_d;
    end
  end

  // A send press always wins the cycle; any out press that collides with it
  // is parked in out_pending and issued on the next free cycle.
  always_comb begin
    send_strobe_d = send_press;
    out_strobe_d  = !send_press && (out_press || out_pending_q);
    out_pending_d = send_press && (out_pending_q || out_press);
    num_d         = send_press ? sw_sync_q : num_q;
    sent_count_d  = sent_count_q + CNT_W'(send_strobe_q);
    out_now_d     = out_now_q + CNT_W'(out_strobe_q);
  end

  assign bus.num         = num_q;
  assign bus.send_strobe = send_strobe_q;
  assign bus.out_strobe  = out_strobe_q;
  assign bus.sent_count  = sent_count_q;
  assign bus.out_now     = out_now_q;

endmodule
